mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//  Upstream sequencer for the 16:1 bit mux (mux16to1). On start, it steps the mux select
//  through every input index. After a programmable settle time it samples the mux output bit.
//  It streams each sampled bit with its index and rebuilds the full word for downstream logic.
//  Used to serialise a parallel word through a single mux output line.
// PARAMETERS
//  SEL_W      4   select width; N = 2**SEL_W mux inputs, scanned per frame
//  DWELL      1   cycles sel is held per index before sampling (>=1)
//  MSB_FIRST  0   0: scan idx 0..N-1; 1: scan idx N-1..0
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request a scan frame; honoured only when busy=0
//  mux_out    in   1      mux output bit (F of the mux under control)
//  sel        out  SEL_W  mux select, registered
//  busy       out  1      high from the edge start is accepted until done is asserted
//  bit_valid  out  1      one-cycle strobe: bit_data/bit_idx valid
//  bit_data   out  1      sampled mux_out for bit_idx
//  bit_idx    out  SEL_W  index that bit_data was sampled at
//  word       out  N      reassembled word; word[i] = sample taken at sel=i
//  done       out  1      one-cycle pulse, coincident with the last bit_valid
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE.
//    - sel=0; busy=0; bit_valid=0; bit_data=0; bit_idx=0; word=0; done=0; dwell counter=0.
//    - A reset mid-frame aborts the frame immediately. No done pulse is produced.
//  - FSM states: IDLE, SCAN.
//    - IDLE + start: -> SCAN.
//      - sel = first index (0, or N-1 if MSB_FIRST); busy=1; dwell counter=0; word cleared.
//    - IDLE + !start: remain in IDLE. sel holds its last value.
//    - SCAN: the dwell counter increments each cycle. The sample cycle is the one where
//      counter == DWELL-1. On that cycle's closing edge:
//      - bit_data <= mux_out; bit_idx <= sel; word[sel] <= mux_out; bit_valid <= 1;
//        dwell counter <= 0.
//      - If sel is not the last index: sel steps to the next index (+1, or -1 if MSB_FIRST).
//      - If sel is the last index: done <= 1; busy <= 0; -> IDLE; sel holds.
//    - bit_valid and done are high for exactly one cycle per assertion.
//  - Timing: if start is accepted at edge E, sample k (k=0..N-1) is taken at edge
//    E+(k+1)*DWELL and is visible in the following cycle. done is high in the cycle after
//    edge E+N*DWELL. A frame occupies N*DWELL cycles.
//  - start while busy: ignored and not queued.
//    - start high in the done cycle: accepted, because state is already IDLE. A new frame
//      begins with no idle gap.
//  - word is stable and complete from the done cycle until the next accepted start.
//  - sel never wraps mid-frame. Index counting wraps only by restarting a frame.
// CONFIGURATION
//  MUX_SCAN_PAUSE_EN defined:
//  - Adds input port `pause` (1 bit), placed after mux_out.
//  - pause=1 in SCAN freezes sel and the dwell counter. No sample is taken.
//  - bit_valid/done are not asserted while pause=1. They resume when pause drops.
//  - pause is ignored in IDLE.
//  - rst overrides pause.
//  MUX_SCAN_PAUSE_EN undefined:
//  - No pause port. The scan runs uninterrupted.
// TESTING (bench models the 16:1 mux: mux_out = A[sel])
//  - rst=1 for 2 cycles, then 0.
//    -> all outputs 0, busy=0, and they stay 0 with start=0 for 10 cycles.
//  - A=16'h3f0a, DWELL=1, start pulse.
//    -> 16 bit_valid strobes, idx 0..15, bits 0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0.
//    -> done in the 17th cycle after start; word=16'h3f0a.
//  - MSB_FIRST=1, DWELL=3, A=16'h8001.
//    -> bit_idx 15..0, each strobe 3 cycles apart; first bit=1, last bit=1.
//    -> done 49 cycles after start; word=16'h8001.
//  - start held high continuously, A=16'hA5A5.
//    -> busy drops only in the done cycle; back-to-back frames with no gap; each word=16'hA5A5.
//  - rst asserted at sample 7 of a frame.
//    -> next cycle: busy=0, word=0, sel=0, no done pulse.
//    -> a fresh start then completes normally.
//  - MUX_SCAN_PAUSE_EN: pause=1 for 5 cycles after sample 3.
//    -> sel frozen, no strobes in that window.
//    -> frame ends 5 cycles late; word still correct.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select sequencer that serialises a 16:1 mux output into strobes and a word
//
// Steps the mux select through every input index once per frame, holds each index for
// DWELL cycles, then samples mux_out. Each sample is emitted as a one-cycle strobe with
// its index, and is also written into the reassembled word.
//
// Parameters:
//   SEL_W      select width; N = 2**SEL_W inputs scanned per frame
//   DWELL      cycles sel is held per index before sampling (>= 1)
//   MSB_FIRST  0: scan 0..N-1, 1: scan N-1..0
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts a frame without a done pulse
//   start      frame request, honoured only while idle
//   mux_out    mux output bit under control
//   pause      (MUX_SCAN_PAUSE_EN only) freezes an active scan
//   sel        registered mux select
//   busy       high from start acceptance until done is asserted
//   bit_valid  one-cycle strobe qualifying bit_data/bit_idx
//   bit_data   sampled mux_out
//   bit_idx    index bit_data was sampled at
//   word       reassembled word, word[i] = sample taken at sel=i
//   done       one-cycle pulse coincident with the last bit_valid
//
// Build option: define MUX_SCAN_PAUSE_EN to add the pause input.

module mux_scan_ctrl #(
    parameter int SEL_W     = 4,
    parameter int DWELL     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mux_out,
`ifdef MUX_SCAN_PAUSE_EN
    input  logic                    pause,
`endif
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic                    bit_valid,
    output logic                    bit_data,
    output logic [SEL_W-1:0]        bit_idx,
    output logic [(2**SEL_W)-1:0]   word,
    output logic                    done
);

    localparam int N     = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(N-1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(N-1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL-1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               bit_valid_q, bit_valid_d;
    logic               bit_data_q, bit_data_d;
    logic [SEL_W-1:0]   bit_idx_q, bit_idx_d;
    logic [N-1:0]       word_q, word_d;
    logic               done_q, done_d;
    logic               paused;

`ifdef MUX_SCAN_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        bit_valid_d = 1'b0;
        bit_data_d  = bit_data_q;
        bit_idx_d   = bit_idx_q;
        word_d      = word_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    sel_d   = FIRST_IDX;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            SCAN: begin
                // pause freezes sel and the dwell count, so no sample can fire
                if (!paused) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        bit_valid_d    = 1'b1;
                        bit_data_d     = mux_out;
                        bit_idx_d      = sel_q;
                        word_d[sel_q]  = mux_out;
                        if (sel_q == LAST_IDX) begin
                            // sel holds at the last index; it never wraps mid-frame
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else if (MSB_FIRST) begin
                            sel_d = sel_q - SEL_W'(1);
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            bit_idx_q   <= '0;
            word_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
            bit_idx_q   <= bit_idx_d;
            word_q      <= word_d;
            done_q      <= done_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign bit_valid = bit_valid_q;
    assign bit_data  = bit_data_q;
    assign bit_idx   = bit_idx_q;
    assign word      = word_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a modelled 16:1 mux
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_w     [2];
    logic        mux_out_w   [2];
    logic [3:0]  sel_w       [2];
    logic        busy_w      [2];
    logic        bit_valid_w [2];
    logic        bit_data_w  [2];
    logic [3:0]  bit_idx_w   [2];
    logic [15:0] word_w      [2];
    logic        done_w      [2];
    logic [15:0] a_w         [2];
`ifdef MUX_SCAN_PAUSE_EN
    logic        pause_w     [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // 16:1 mux model: F = A[sel]
    assign mux_out_w[0] = a_w[0][sel_w[0]];
    assign mux_out_w[1] = a_w[1][sel_w[1]];

    mux_scan_ctrl #(.SEL_W(4), .DWELL(1), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .mux_out(mux_out_w[0]),
`ifdef MUX_SCAN_PAUSE_EN
        .pause(pause_w[0]),
`endif
        .sel(sel_w[0]), .busy(busy_w[0]), .bit_valid(bit_valid_w[0]),
        .bit_data(bit_data_w[0]), .bit_idx(bit_idx_w[0]), .word(word_w[0]),
        .done(done_w[0])
    );

    mux_scan_ctrl #(.SEL_W(4), .DWELL(3), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .mux_out(mux_out_w[1]),
`ifdef MUX_SCAN_PAUSE_EN
        .pause(pause_w[1]),
`endif
        .sel(sel_w[1]), .busy(busy_w[1]), .bit_valid(bit_valid_w[1]),
        .bit_data(bit_data_w[1]), .bit_idx(bit_idx_w[1]), .word(word_w[1]),
        .done(done_w[1])
    );

    // Reference model: frame of 16 samples, sample k taken after (k+1)*dwell active
    // (unpaused) edges; index order set by scan direction.
    task automatic run_frame(input int d, input logic [15:0] a, input bit hold,
                             input int p_at, input int p_len, input string tag);
        int dw;
        bit mf;
        int eff;
        int k;
        bit paused;
        bit strobe;
        logic [3:0] exp_idx;
        logic [3:0] exp_sel;
        dw  = (d == 0) ? 1 : 3;
        mf  = (d == 1);
        eff = 0;
        a_w[d]     = a;
        start_w[d] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_w[d] = 1'b0;
        exp_sel = mf ? 4'd15 : 4'd0;
        n_checks++;
        if (busy_w[d] !== 1'b1 || sel_w[d] !== exp_sel || word_w[d] !== 16'h0 || bit_valid_w[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b sel=%0d word=%h bv=%b, need busy=1 sel=%0d word=0000 bv=0",
                     tag, busy_w[d], sel_w[d], word_w[d], bit_valid_w[d], exp_sel);
        end
        for (int c = 1; c <= 16*dw + p_len; c++) begin
            paused = (p_len > 0) && (c > p_at) && (c <= p_at + p_len);
`ifdef MUX_SCAN_PAUSE_EN
            pause_w[d] = paused;
`endif
            @(posedge clk); #1;
            if (!paused) eff++;
            strobe  = !paused && (eff % dw == 0);
            k       = strobe ? (eff / dw - 1) : 0;
            exp_idx = mf ? 4'(15 - k) : 4'(k);
            n_checks++;
            if (bit_valid_w[d] !== strobe) begin
                n_fail++;
                $display("FAIL %s bit_valid c=%0d: got %b need %b", tag, c, bit_valid_w[d], strobe);
            end
            if (strobe) begin
                n_checks++;
                if (bit_idx_w[d] !== exp_idx || bit_data_w[d] !== a[exp_idx]) begin
                    n_fail++;
                    $display("FAIL %s bit c=%0d: idx=%0d data=%b need idx=%0d data=%b",
                             tag, c, bit_idx_w[d], bit_data_w[d], exp_idx, a[exp_idx]);
                end
            end
            n_checks++;
            if (done_w[d] !== (strobe && eff == 16*dw) || busy_w[d] !== (eff < 16*dw)) begin
                n_fail++;
                $display("FAIL %s done/busy c=%0d: done=%b busy=%b need done=%b busy=%b", tag, c,
                         done_w[d], busy_w[d], (strobe && eff == 16*dw), (eff < 16*dw));
            end
            if (eff < 16*dw) exp_sel = mf ? 4'(15 - eff/dw) : 4'(eff/dw);
            else             exp_sel = mf ? 4'd0 : 4'd15;
            n_checks++;
            if (sel_w[d] !== exp_sel) begin
                n_fail++;
                $display("FAIL %s sel c=%0d: got %0d need %0d", tag, c, sel_w[d], exp_sel);
            end
        end
`ifdef MUX_SCAN_PAUSE_EN
        pause_w[d] = 1'b0;
`endif
        n_checks++;
        if (word_w[d] !== a) begin
            n_fail++;
            $display("FAIL %s word: got %h need %h", tag, word_w[d], a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({sel_w[d], busy_w[d], bit_valid_w[d], bit_data_w[d], bit_idx_w[d], word_w[d], done_w[d]} !== 27'h0) begin
                    n_fail++;
                    $display("FAIL reset dut%0d c=%0d: sel=%0d busy=%b bv=%b bd=%b idx=%0d word=%h done=%b, need all 0",
                             d, c, sel_w[d], busy_w[d], bit_valid_w[d], bit_data_w[d], bit_idx_w[d], word_w[d], done_w[d]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_scan_lsb();
        run_frame(0, 16'h3f0a, 1'b0, 0, 0, "lsb_3f0a");
        @(posedge clk); #1;
    endtask

    task automatic test_scan_msb();
        run_frame(1, 16'h8001, 1'b0, 0, 0, "msb_8001");
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_frame(0, 16'($urandom), 1'b0, 0, 0, "rand_lsb");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_frame(1, 16'($urandom), 1'b0, 0, 0, "rand_msb");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        run_frame(0, 16'hffff, 1'b0, 0, 0, "ones");
        run_frame(0, 16'h0000, 1'b0, 0, 0, "zeros");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_frame(0, 16'hA5A5, 1'b1, 0, 0, "b2b");
        start_w[0] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: busy=%b need 0", busy_w[0]);
        end
    endtask

    task automatic test_reset_mid();
        a_w[0]     = 16'($urandom);
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (busy_w[0] !== 1'b0 || word_w[0] !== 16'h0 || sel_w[0] !== 4'd0 || done_w[0] !== 1'b0 || bit_valid_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b word=%h sel=%0d done=%b bv=%b, need all 0",
                     busy_w[0], word_w[0], sel_w[0], done_w[0], bit_valid_w[0]);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || bit_valid_w[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet c=%0d: done=%b busy=%b bv=%b need 0", c, done_w[0], busy_w[0], bit_valid_w[0]);
            end
        end
        run_frame(0, 16'($urandom), 1'b0, 0, 0, "after_rst");
    endtask

`ifdef MUX_SCAN_PAUSE_EN
    task automatic test_pause();
        run_frame(0, 16'($urandom), 1'b0, 4, 5, "pause_lsb");
        run_frame(1, 16'($urandom), 1'b0, 7, 4, "pause_msb");
    endtask
`endif

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_w[d] = 1'b0;
            a_w[d]     = 16'h0;
`ifdef MUX_SCAN_PAUSE_EN
            pause_w[d] = 1'b0;
`endif
        end
        test_reset();
        test_scan_lsb();
        test_scan_msb();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef MUX_SCAN_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
